// File: rtl/tinyriscv_pkg.sv
// Shared core constants and types used by the execute-stage divider.
package tinyriscv_pkg;

    // Reset level and divider handshake values
    localparam logic RstEnable         = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // RV32M divide-family funct3 encodings
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    // One quotient bit is produced per CALC cycle
    localparam int DivIterations = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_START,
        DIV_CALC,
        DIV_END
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: zero dividend or zero divisor skips CALC.
module ex_div
    import tinyriscv_pkg::*;
#(
    parameter int XLEN = DivIterations
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o
);

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    div_state_e      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] dividend_q, dividend_d;   // operands as issued
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [4:0]      waddr_q, waddr_d;         // pending destination
    logic [XLEN-1:0] dvd_q, dvd_d;             // dividend bits out, quotient bits in
    logic [XLEN-1:0] dsr_q, dsr_d;             // divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;             // partial remainder
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            dz_q, dz_d;               // divide by zero
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;
    logic [4:0]      waddr_o_q, waddr_o_d;

    // Operand conditioning for START
    logic            signed_op, is_rem, s_a, s_b;
    logic [XLEN-1:0] mag_a, mag_b;
    assign signed_op = (op_q == INST_DIV) || (op_q == INST_REM);
    assign is_rem    = (op_q == INST_REM) || (op_q == INST_REMU);
    assign s_a       = signed_op & dividend_q[XLEN-1];
    assign s_b       = signed_op & divisor_q[XLEN-1];
    assign mag_a     = s_a ? neg(dividend_q) : dividend_q;
    assign mag_b     = s_b ? neg(divisor_q)  : divisor_q;

    // One restoring step: the shifted remainder needs one extra bit for the compare
    logic [XLEN:0]   rem_sh;
    logic            q_bit;
    logic [XLEN-1:0] rem_sub;
    assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
    assign q_bit   = (rem_sh >= {1'b0, dsr_q});
    assign rem_sub = rem_sh[XLEN-1:0] - dsr_q;

    // Sign fix-up; RISC-V wants an all-ones quotient on divide by zero regardless of sign
    logic [XLEN-1:0] q_fin, r_fin;
    assign q_fin = dz_q ? {XLEN{1'b1}} : (q_neg_q ? neg(dvd_q) : dvd_q);
    assign r_fin = r_neg_q ? neg(rem_q) : rem_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= DIV_IDLE;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            waddr_q    <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
            waddr_o_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            waddr_q    <= waddr_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            waddr_o_q  <= waddr_o_d;
        end
    end

    // Next-state and datapath control; dropping start_i outside IDLE aborts quietly
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        waddr_d    = waddr_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        result_d   = result_q;
        ready_d    = DivResultNotReady;
        waddr_o_d  = waddr_o_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i && (ready_q == DivResultNotReady)) begin
                    state_d    = DIV_START;
                    op_d       = op_i;
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    waddr_d    = reg_waddr_i;
                end
            end
            DIV_START: begin
                if (!start_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    dvd_d   = mag_a;
                    dsr_d   = mag_b;
                    q_neg_d = s_a ^ s_b;
                    r_neg_d = s_a;
                    dz_d    = (divisor_q == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV_CALC;
`ifdef DIV_EARLY_OUT_EN
                    // Trivial cases: quotient/remainder magnitudes are known up front
                    if ((divisor_q == '0) || (dividend_q == '0)) begin
                        dvd_d   = (divisor_q == '0) ? {XLEN{1'b1}} : '0;
                        rem_d   = (divisor_q == '0) ? mag_a : '0;
                        state_d = DIV_END;
                    end
`endif
                end
            end
            DIV_CALC: begin
                if (!start_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = q_bit ? rem_sub : rem_sh[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], q_bit};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_END: begin
                state_d = DIV_IDLE;
                if (start_i) begin
                    result_d  = is_rem ? r_fin : q_fin;
                    ready_d   = DivResultReady;
                    waddr_o_d = waddr_q;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign reg_waddr_o = waddr_o_q;
    assign busy_o      = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_ex_div.sv
// Directed + randomized bench for ex_div with a result scoreboard.
module tb_ex_div;
    import tinyriscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] last_res = '0;
    logic [4:0]  last_wa = '0;
    logic        prev_rdy = 1'b0;
    int          rdy_cnt = 0;
    logic [4:0]  wa_ctr = 5'd1;

`ifdef DIV_EARLY_OUT_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    always #5 clk = ~clk;

    ex_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain SV arithmetic plus the RISC-V corner rules
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic sgn, remop;
        sgn   = (op == INST_DIV) || (op == INST_REM);
        remop = (op == INST_REM) || (op == INST_REMU);
        if (b == 32'd0) return remop ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return remop ? 32'd0 : 32'h8000_0000;
        if (sgn) return remop ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return remop ? a % b : a / b;
    endfunction

    function automatic int lat_for(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'd0 || b == 32'd0) ? ZLAT : 34;
    endfunction

    // Scoreboard side: every ready pulse consumes one expected entry
    always @(negedge clk) begin
        if (ready_o === 1'b1) begin
            rdy_cnt++;
            chk("ready_one_cycle", {31'b0, prev_rdy}, 32'd0);
            chk("busy_with_ready", {31'b0, busy_o}, 32'd0);
            chk("sb_nonempty", {31'b0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("result", result_o, mon_e.res);
                chk("waddr", {27'b0, reg_waddr_o}, {27'b0, mon_e.wa});
                last_res = mon_e.res;
                last_wa  = mon_e.wa;
            end
        end
        prev_rdy = ready_o;
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while ((ready_o === 1'b1 || busy_o === 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Issue one op, scramble inputs after accept, hold start until ready
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic got;
        @(negedge clk);
        wait_idle();
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa_ctr;
        sbq.push_back('{exp, wa_ctr});
        wa_ctr      = wa_ctr + 5'd1;
        @(posedge clk);
        #1;
        op_i        = 3'($urandom);
        dividend_i  = $urandom;
        divisor_i   = $urandom;
        reg_waddr_i = 5'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o === 1'b1) got = 1'b1;
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int          r0;
        logic [31:0] a, b;
        logic [2:0]  op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result_o, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_waddr", {27'b0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("div_100_7",  INST_DIV,  32'd100, 32'd7, 32'd14, 34);
        run_op("rem_100_7",  INST_REM,  32'd100, 32'd7, 32'd2,  34);
        run_op("divu_max_2", INST_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
        run_op("remu_max_2", INST_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
        run_op("div_m7_2",   INST_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",   INST_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div_7_m2",   INST_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2",   INST_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("div_5_0",    INST_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
        run_op("rem_5_0",    INST_REM,  32'd5, 32'd0, 32'd5, ZLAT);
        run_op("remu_min_0", INST_REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, ZLAT);
        run_op("div_m5_0",   INST_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, ZLAT);
        run_op("rem_m5_0",   INST_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ZLAT);
        run_op("divu_0_3",   INST_DIVU, 32'd0, 32'd3, 32'd0, ZLAT);
        run_op("div_ovf",    INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("rem_ovf",    INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            op = 3'(4 + (i % 4));
            run_op("rand", op, a, b, ref_res(op, a, b), lat_for(a, b));
        end

        // Abort 10 cycles into CALC
        @(negedge clk);
        wait_idle();
        start_i     = 1'b1;
        op_i        = INST_DIVU;
        dividend_i  = 32'd1000;
        divisor_i   = 32'd3;
        reg_waddr_i = 5'd30;
        @(posedge clk);
        repeat (11) @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        r0 = rdy_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_ready", 32'(rdy_cnt), 32'(r0));
        chk("abort_result_kept", result_o, last_res);
        chk("abort_waddr_kept", {27'b0, reg_waddr_o}, {27'b0, last_wa});

        run_op("after_abort", INST_DIV, 32'd100, 32'd7, 32'd14, 34);

        // Reset in the middle of CALC
        @(negedge clk);
        wait_idle();
        start_i     = 1'b1;
        op_i        = INST_DIV;
        dividend_i  = 32'd500;
        divisor_i   = 32'd9;
        reg_waddr_i = 5'd29;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_ready", {31'b0, ready_o}, 32'd0);
        chk("midrst_busy", {31'b0, busy_o}, 32'd0);
        chk("midrst_waddr", {27'b0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("after_rst", INST_REMU, 32'd100, 32'd7, 32'd2, 34);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
